// File: rtl/lsu_rmw.sv
// Load/store unit bridging byte/half/word CPU accesses onto a word-only data memory via read-modify-write.
// Optional misalignment trapping is enabled by defining LSU_ALIGN_CHECK_EN.
module lsu_rmw #(
    parameter int unsigned MEM_AW = 10
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wd_i,
    input  logic [31:0] req_pc_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rd_o,
    output logic        resp_err_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    // Only the fields still needed after acceptance; the word address lives in mem_addr_q.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [15:0] wd;
    } req_t;

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wd_q, mem_wd_d;
    logic              mem_we_q, mem_we_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_rd_q, resp_rd_d;
    logic              resp_err_q, resp_err_d;
    logic              misalign_c;
    logic              unused_pc;

    // The PC is carried for trace purposes only.
    assign unused_pc = ^req_pc_i;

`ifdef LSU_ALIGN_CHECK_EN
    assign misalign_c = ((req_size_i == 2'd1) && req_addr_i[0]) ||
                        (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    function automatic logic [XLEN-1:0] store_merge(
        input logic [XLEN-1:0] word,
        input logic [1:0]      size,
        input logic [1:0]      off,
        input logic [15:0]     wd
    );
        logic [XLEN-1:0] r;
        r = word;
        if (size == 2'd0) begin
            r[{off, 3'b000} +: 8] = wd[7:0];
        end else begin
            r[{off[1], 4'b0000} +: 16] = wd;
        end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] load_extract(
        input logic [XLEN-1:0] word,
        input logic [1:0]      size,
        input logic            uns,
        input logic [1:0]      off
    );
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            2'd0:    r = {{24{b[7] & ~uns}}, b};
            2'd1:    r = {{16{h[15] & ~uns}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        mem_addr_d   = mem_addr_q;
        mem_wd_d     = mem_wd_q;
        mem_we_d     = 1'b0;
        resp_valid_d = 1'b0;
        resp_rd_d    = '0;
        resp_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    req_d.we   = req_we_i;
                    req_d.size = req_size_i;
                    req_d.uns  = req_unsigned_i;
                    req_d.off  = req_addr_i[1:0];
                    req_d.wd   = req_wd_i[15:0];
                    // Bits above the memory's word index ride along untouched.
                    mem_addr_d = {req_addr_i[XLEN-1:MEM_AW+2], req_addr_i[MEM_AW+1:2], 2'b00};
                    if (misalign_c) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        state_d      = S_RESP;
                    end else if (req_we_i && req_size_i[1]) begin
                        mem_we_d = 1'b1;
                        mem_wd_d = req_wd_i;
                        state_d  = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (req_q.we) begin
                    mem_wd_d = store_merge(mem_rd_i, req_q.size, req_q.off, req_q.wd);
                    mem_we_d = 1'b1;
                    state_d  = S_WRITE;
                end else begin
                    resp_rd_d    = load_extract(mem_rd_i, req_q.size, req_q.uns, req_q.off);
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_WRITE: begin
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Async reset clears mem_we_q at once, aborting any pending write.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            req_q        <= '0;
            mem_addr_q   <= '0;
            mem_wd_q     <= '0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rd_q    <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            mem_addr_q   <= mem_addr_d;
            mem_wd_q     <= mem_wd_d;
            mem_we_q     <= mem_we_d;
            resp_valid_q <= resp_valid_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready_o  = (state_q == S_IDLE) & reset_ni;
    assign resp_valid_o = resp_valid_q;
    assign resp_rd_o    = resp_rd_q;
    assign resp_err_o   = resp_err_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_we_o     = mem_we_q;
    assign mem_wd_o     = mem_wd_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw: word memory responder, byte-level reference model and per-cycle compare.
// Honours LSU_ALIGN_CHECK_EN the same way the design does.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wd;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rd;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    lsu_rmw #(.MEM_AW(10)) dut (
        .clk_i          (clk),
        .reset_ni       (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wd_i       (req_wd),
        .req_pc_i       (req_pc),
        .resp_valid_o   (resp_valid),
        .resp_rd_o      (resp_rd),
        .resp_err_o     (resp_err),
        .mem_addr_o     (mem_addr),
        .mem_we_o       (mem_we),
        .mem_wd_o       (mem_wd),
        .mem_rd_i       (mem_rd)
    );

    // Word memory responder: combinational read, write on the clock edge, plus a preload port.
    logic [31:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = 8'd0;
    logic [31:0] pl_val = 32'd0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (mem_we) mem[mem_addr[9:2]] <= mem_wd;
    end
    assign mem_rd = mem[mem_addr[9:2]];

    // Reference model state.
    logic [31:0] shadow [0:255];
    int          cyc = 0;
    int          acc_cyc = -1, read_cyc = -1, we_cyc = -1, resp_cyc = -1;
    logic [31:0] exp_addr, exp_wd, exp_rd;
    logic        exp_err;
    logic [31:0] last_rd, last_wd;
    logic        last_err;
    int          last_lat;
    int          n_chk = 0, n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Per-cycle comparison of every DUT output against the model's expectations.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_resp_rd", resp_rd, 32'd0);
            chk("rst_resp_err", 32'(resp_err), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_mem_wd", mem_wd, 32'd0);
        end else begin
            chk("req_ready", 32'(req_ready),
                32'(!(acc_cyc >= 0 && cyc > acc_cyc && cyc <= resp_cyc)));
            chk("resp_valid", 32'(resp_valid), 32'(cyc == resp_cyc));
            if (cyc == resp_cyc) begin
                chk("resp_rd", resp_rd, exp_rd);
                chk("resp_err", 32'(resp_err), 32'(exp_err));
                last_rd  = resp_rd;
                last_err = resp_err;
                last_lat = cyc - acc_cyc;
            end
            chk("mem_we", 32'(mem_we), 32'(cyc == we_cyc));
            if (cyc == we_cyc) begin
                chk("write_addr", mem_addr, exp_addr);
                chk("write_data", mem_wd, exp_wd);
                last_wd = mem_wd;
                shadow[exp_addr[9:2]] = exp_wd;
            end
            if (cyc == read_cyc) chk("read_addr", mem_addr, exp_addr);
        end
    end

    // Byte-granular model of one accepted request; sets the cycles at which things must happen.
    task automatic model_issue(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wd);
        int          sz, off, lat;
        bit          mis;
        logic [31:0] old, nw, v, mask;
        old  = shadow[addr[9:2]];
        sz   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis  = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        mis = (int'(addr[1:0]) % sz) != 0;
`endif
        exp_addr = {addr[31:2], 2'b00};
        acc_cyc  = cyc;
        read_cyc = -1;
        we_cyc   = -1;
        exp_rd   = 32'd0;
        exp_err  = 1'b0;
        if (mis) begin
            exp_err  = 1'b1;
            resp_cyc = cyc + 1;
        end else begin
            off = (sz == 4) ? 0 : (sz == 2) ? 2 * int'(addr[1]) : int'(addr[1:0]);
            if (we) begin
                nw = old;
                for (int b = 0; b < sz; b++) nw[8*(off+b) +: 8] = wd[8*b +: 8];
                exp_wd = nw;
                lat    = (sz == 4) ? 2 : 3;
                we_cyc = cyc + lat - 1;
                if (sz != 4) read_cyc = cyc + 1;
            end else begin
                mask = (sz == 1) ? 32'h0000_00FF : (sz == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
                v = (old >> (8 * off)) & mask;
                if (!uns && sz < 4 && v[8*sz-1]) v = v | ~mask;
                exp_rd   = v;
                lat      = 2;
                read_cyc = cyc + 1;
            end
            resp_cyc = cyc + lat;
        end
    endtask

    task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
        @(negedge clk);
        #1;
        pl_en  = 1'b1;
        pl_idx = addr[9:2];
        pl_val = val;
        shadow[addr[9:2]] = val;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input bit hold, input bit wait_done);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!req_ready && n < 20);
        if (!req_ready) begin
            chk("ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wd       = wd;
        req_pc       = 32'h0000_1000 + addr;
        model_issue(we, size, uns, addr, wd);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        if (wait_done) begin
            n = 0;
            do begin
                @(negedge clk);
                #1;
                n++;
            end while (cyc < resp_cyc && n < 20);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int a0, a1, a2;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wd = 32'd0; req_pc = 32'd0;
        for (int i = 0; i < 256; i++) shadow[i] = 32'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Word store.
        set_word(32'h10, 32'h0000_0000);
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1);
        chk("sw_data", last_wd, 32'hDEAD_BEEF);
        chk("sw_latency", 32'(last_lat), 32'd2);
        chk("sw_err", 32'(last_err), 32'd0);
        chk("sw_mem", mem[4], 32'hDEAD_BEEF);

        // Byte store merges into lane 2.
        do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_005A, 1'b0, 1'b1);
        chk("sb_data", last_wd, 32'hDE5A_BEEF);
        chk("sb_latency", 32'(last_lat), 32'd3);

        // Sub-word loads with sign/zero extension.
        set_word(32'h20, 32'h8001_F234);
        do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'd0, 1'b0, 1'b1);
        chk("lh_0x22", last_rd, 32'hFFFF_8001);
        chk("lh_latency", 32'(last_lat), 32'd2);
        do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'd0, 1'b0, 1'b1);
        chk("lhu_0x22", last_rd, 32'h0000_8001);
        do_req(1'b0, 2'd0, 1'b0, 32'h20, 32'd0, 1'b0, 1'b1);
        chk("lb_0x20", last_rd, 32'h0000_0034);
        do_req(1'b0, 2'd0, 1'b0, 32'h21, 32'd0, 1'b0, 1'b1);
        chk("lb_0x21", last_rd, 32'hFFFF_FFF2);
        do_req(1'b0, 2'd0, 1'b1, 32'h23, 32'd0, 1'b0, 1'b1);
        chk("lbu_0x23", last_rd, 32'h0000_0080);
        do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'd0, 1'b0, 1'b1);
        chk("lw_size3", last_rd, 32'h8001_F234);
        do_req(1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'd0, 1'b0, 1'b1);
        chk("lw_high_addr", last_rd, 32'h8001_F234);

        // Half store at an odd address.
        do_req(1'b1, 2'd1, 1'b0, 32'h13, 32'h0000_1234, 1'b0, 1'b1);
`ifdef LSU_ALIGN_CHECK_EN
        chk("sh_mis_err", 32'(last_err), 32'd1);
        chk("sh_mis_latency", 32'(last_lat), 32'd1);
        chk("sh_mis_mem", mem[4], 32'hDE5A_BEEF);
`else
        chk("sh_odd_err", 32'(last_err), 32'd0);
        chk("sh_odd_latency", 32'(last_lat), 32'd3);
        chk("sh_odd_mem", mem[4], 32'h1234_BEEF);
`endif
        // Misaligned word accesses and a low-half store.
        do_req(1'b0, 2'd2, 1'b0, 32'h22, 32'd0, 1'b0, 1'b1);
        do_req(1'b1, 2'd2, 1'b0, 32'h25, 32'hCAFE_F00D, 1'b0, 1'b1);
        do_req(1'b1, 2'd1, 1'b0, 32'h20, 32'h0000_AAAA, 1'b0, 1'b1);
        chk("sh_low_mem", mem[8], 32'h8001_AAAA);

        // Reset during the WRITE cycle of a byte store.
        set_word(32'h30, 32'h1122_3344);
        do_req(1'b1, 2'd0, 1'b0, 32'h31, 32'h0000_0099, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        acc_cyc = -1; read_cyc = -1; we_cyc = -1; resp_cyc = -1;
        shadow[12] = 32'h1122_3344;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_reset_ready", 32'(req_ready), 32'd1);
        chk("abort_word", mem[12], 32'h1122_3344);

        // Back-to-back loads with req_valid held high.
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 1'b1, 1'b1);
        a0 = acc_cyc;
        chk("b2b_lw", last_rd, 32'h8001_AAAA);
        do_req(1'b0, 2'd0, 1'b0, 32'h22, 32'd0, 1'b1, 1'b1);
        a1 = acc_cyc;
        chk("b2b_lb", last_rd, 32'h0000_0001);
        do_req(1'b0, 2'd1, 1'b1, 32'h20, 32'd0, 1'b0, 1'b1);
        a2 = acc_cyc;
        chk("b2b_lhu", last_rd, 32'h0000_AAAA);
        chk("b2b_gap0", 32'(a1 - a0), 32'd3);
        chk("b2b_gap1", 32'(a2 - a1), 32'd3);

        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) chk("mem_vs_model", mem[i], shadow[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
